// File: rtl/arb_grant_lock_mux_if.sv
// -----------------------------------------------------------------------------
// arb_grant_lock_mux_if
//
// Purpose: bundles every bus signal of arb_grant_lock_mux. Clock and reset
// are kept as plain ports on the module.
//
// Handshake rule (all valid/ready pairs in this bundle):
//   A beat transfers on a rising clk edge where valid and ready are both 1.
//   A source holds valid and its payload stable until that transfer. Ready
//   may depend combinationally on valid. Valid must never wait on ready.
//
// Signal summary (WIDTH requesters, DW payload bits, CNT_W counter bits):
//   in_valid  [WIDTH]     requester beat valid
//   in_data   [WIDTH*DW]  requester i payload at [i*DW +: DW]
//   in_last   [WIDTH]     requester last-beat flag
//   in_ready  [WIDTH]     per-requester ready
//   arb_req   [WIDTH]     request vector to the external arbiter
//   arb_gnt   [WIDTH]     one-hot grant back from the arbiter
//   out_valid / out_data / out_last / out_ready   muxed output channel
//   owner     [WIDTH]     registered one-hot of the locked requester
//   busy                  1 while a packet holds the lock
//   beat_cnt  [CNT_W]     beats accepted in the current packet (saturating)
//   gnt_err               sticky illegal-grant flag
//   state_dbg             raw FSM state (0 = IDLE, 1 = LOCK)
//
// Modports:
//   slave  - the arb_grant_lock_mux side
//   master - the environment side (requesters, arbiter, downstream sink)
// -----------------------------------------------------------------------------
interface arb_grant_lock_mux_if #(
    parameter int WIDTH = 16,
    parameter int DW    = 32,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]    in_valid;
    logic [WIDTH*DW-1:0] in_data;
    logic [WIDTH-1:0]    in_last;
    logic [WIDTH-1:0]    in_ready;
    logic [WIDTH-1:0]    arb_req;
    logic [WIDTH-1:0]    arb_gnt;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic                out_last;
    logic                out_ready;
    logic [WIDTH-1:0]    owner;
    logic                busy;
    logic [CNT_W-1:0]    beat_cnt;
    logic                gnt_err;
    logic                state_dbg;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  arb_gnt,
        input  out_ready,
        output in_ready,
        output arb_req,
        output out_valid,
        output out_data,
        output out_last,
        output owner,
        output busy,
        output beat_cnt,
        output gnt_err,
        output state_dbg
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output arb_gnt,
        output out_ready,
        input  in_ready,
        input  arb_req,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  owner,
        input  busy,
        input  beat_cnt,
        input  gnt_err,
        input  state_dbg
    );
endinterface

// File: rtl/arb_grant_lock_mux.sv
// -----------------------------------------------------------------------------
// arb_grant_lock_mux
//
// Purpose: sits downstream of a fixed-priority arbiter. In IDLE it forwards
// requester valids to the arbiter and samples the one-hot grant. A legal
// grant locks that requester as owner for a whole multi-beat packet, and its
// beats are muxed onto a single valid/ready output. The lock drops after the
// beat carrying last, so every packet is followed by one IDLE cycle in which
// the arbiter is consulted again.
//
// Ports:
//   clk    - single clock, everything on posedge
//   rst_n  - synchronous active-low reset
//   bus    - arb_grant_lock_mux_if.slave (requesters, arbiter, output
//            channel, status: owner / busy / beat_cnt / gnt_err / state_dbg)
//
// Only state, owner, beat_cnt and gnt_err are registered; every other output
// is combinational from those registers and the current inputs.
// -----------------------------------------------------------------------------
module arb_grant_lock_mux #(
    parameter int WIDTH = 16,
    parameter int DW    = 32,
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    arb_grant_lock_mux_if.slave bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             gnt_err_q, gnt_err_d;

    // Grant qualification
    logic gnt_any;
    logic gnt_onehot;
    logic gnt_subset;
    logic gnt_legal;
    logic gnt_illegal;

    // Owner-selected channel
    logic [DW-1:0] mux_data;
    logic          mux_last;
    logic          mux_valid;
    logic          xfer;

    // -------------------------------------------------------------------------
    // Grant checks. A grant is legal only if exactly one bit is set and that
    // bit belongs to a requester that is actually valid. A zero grant is
    // neither legal nor an error: it simply means nobody is asking.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_any     = |bus.arb_gnt;
        gnt_onehot  = gnt_any && ((bus.arb_gnt & (bus.arb_gnt - ONE_W)) == '0);
        gnt_subset  = ((bus.arb_gnt & ~bus.in_valid) == '0);
        gnt_legal   = gnt_onehot && gnt_subset;
        gnt_illegal = gnt_any && !gnt_legal;
    end

    // -------------------------------------------------------------------------
    // AND-OR mux keyed by the one-hot owner. With owner_q == 0 (IDLE) every
    // term is masked off, so data and last read as zero.
    // -------------------------------------------------------------------------
    always_comb begin
        mux_data = '0;
        mux_last = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            mux_data = mux_data | (bus.in_data[i*DW +: DW] & {DW{owner_q[i]}});
            mux_last = mux_last | (bus.in_last[i] & owner_q[i]);
        end
        mux_valid = |(bus.in_valid & owner_q);
    end

    assign xfer = (state_q == ST_LOCK) && mux_valid && bus.out_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        gnt_err_d  = gnt_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_legal) begin
                    state_d    = ST_LOCK;
                    owner_d    = bus.arb_gnt;
                    beat_cnt_d = '0;
                end else if (gnt_illegal) begin
                    // Refuse to lock on a malformed grant; just flag it.
                    gnt_err_d = 1'b1;
                end
            end

            ST_LOCK: begin
                // The arbiter is ignored here: no preemption mid-packet, and
                // a stalled owner keeps the lock for as long as it likes.
                if (xfer) begin
                    if (beat_cnt_q != CNT_MAX) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    if (mux_last) begin
                        state_d    = ST_IDLE;
                        owner_d    = '0;
                        beat_cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                owner_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Combinational outputs
    // -------------------------------------------------------------------------
    always_comb begin
        bus.arb_req   = '0;
        bus.in_ready  = '0;
        bus.out_valid = 1'b0;
        bus.out_data  = mux_data;
        bus.out_last  = mux_last;

        if (state_q == ST_IDLE) begin
            bus.arb_req = bus.in_valid;
        end else begin
            bus.in_ready  = owner_q & {WIDTH{bus.out_ready}};
            bus.out_valid = mux_valid;
        end
    end

    assign bus.owner     = owner_q;
    assign bus.busy      = (state_q == ST_LOCK);
    assign bus.beat_cnt  = beat_cnt_q;
    assign bus.gnt_err   = gnt_err_q;
    assign bus.state_dbg = state_q;

    // -------------------------------------------------------------------------
    // Registers. Reset drops any lock in progress; a partial packet is simply
    // abandoned.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            gnt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            gnt_err_q  <= gnt_err_d;
        end
    end

endmodule

// File: tb/tb_arb_grant_lock_mux.sv
// -----------------------------------------------------------------------------
// tb_arb_grant_lock_mux
//
// Directed bench for arb_grant_lock_mux. Two instances: the default
// configuration (CNT_W=8) and a CNT_W=2 copy for counter saturation. A small
// fixed-priority arbiter model (lowest index wins) answers arb_req; it can be
// overridden to inject malformed grants.
//
// Timing: inputs change 2 time units after posedge, outputs are sampled 1
// unit later, well clear of the next rising edge.
// -----------------------------------------------------------------------------
module tb_arb_grant_lock_mux;

    localparam int WIDTH = 16;
    localparam int DW    = 32;

    logic clk;
    logic rst_n;

    // Grant override for illegal-grant injection
    logic             force_en;
    logic [WIDTH-1:0] force_gnt;

    int compares;
    int fails;

    arb_grant_lock_mux_if #(.WIDTH(WIDTH), .DW(DW), .CNT_W(8)) b  ();
    arb_grant_lock_mux_if #(.WIDTH(WIDTH), .DW(DW), .CNT_W(2)) b2 ();

    arb_grant_lock_mux #(.WIDTH(WIDTH), .DW(DW), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    arb_grant_lock_mux #(.WIDTH(WIDTH), .DW(DW), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2.slave)
    );

    // Fixed-priority arbiter models: gnt = req & ~(req-1)
    assign b.arb_gnt  = force_en ? force_gnt : (b.arb_req & ~(b.arb_req - 16'd1));
    assign b2.arb_gnt = b2.arb_req & ~(b2.arb_req - 16'd1);

    // -------------------------------------------------------------------------
    // Clock and reset
    // -------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int idx, input logic v, input logic [DW-1:0] d, input logic l);
        b.in_valid[idx]         = v;
        b.in_data[idx*DW +: DW] = d;
        b.in_last[idx]          = l;
    endtask

    task automatic set_req2(input int idx, input logic v, input logic [DW-1:0] d, input logic l);
        b2.in_valid[idx]         = v;
        b2.in_data[idx*DW +: DW] = d;
        b2.in_last[idx]          = l;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        int sat_tab [5];
        sat_tab = '{1, 2, 3, 3, 3};
        compares  = 0;
        fails     = 0;
        rst_n     = 1'b0;
        force_en  = 1'b0;
        force_gnt = '0;
        b.in_valid  = '0;
        b.in_data   = '0;
        b.in_last   = '0;
        b.out_ready = 1'b1;
        b2.in_valid  = '0;
        b2.in_data   = '0;
        b2.in_last   = '0;
        b2.out_ready = 1'b1;

        // ---------------- reset state ----------------
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_owner",     b.owner,     16'h0000);
        chk("rst_busy",      b.busy,      1'b0);
        chk("rst_state",     b.state_dbg, 1'b0);
        chk("rst_beat_cnt",  b.beat_cnt,  8'd0);
        chk("rst_gnt_err",   b.gnt_err,   1'b0);
        chk("rst_in_ready",  b.in_ready,  16'h0000);
        chk("rst_out_valid", b.out_valid, 1'b0);
        chk("rst2_owner",    b2.owner,    16'h0000);

        // ---------------- 3-beat packet on req1, then req2 ----------------
        set_req(1, 1'b1, 32'h1111_0001, 1'b0);
        set_req(2, 1'b1, 32'h2222_0001, 1'b1);
        #1;
        chk("t1_idle_arb_req",   b.arb_req,   16'h0006);
        chk("t1_idle_in_ready",  b.in_ready,  16'h0000);
        chk("t1_idle_out_valid", b.out_valid, 1'b0);
        step();
        #1;
        chk("t1_owner",     b.owner,     16'h0002);
        chk("t1_busy",      b.busy,      1'b1);
        chk("t1_state",     b.state_dbg, 1'b1);
        chk("t1_arb_req",   b.arb_req,   16'h0000);
        chk("t1_out_valid", b.out_valid, 1'b1);
        chk("t1_b1_data",   b.out_data,  32'h1111_0001);
        chk("t1_b1_last",   b.out_last,  1'b0);
        chk("t1_in_ready",  b.in_ready,  16'h0002);
        chk("t1_cnt0",      b.beat_cnt,  8'd0);
        step();
        set_req(1, 1'b1, 32'h1111_0002, 1'b0);
        #1;
        chk("t1_b2_data",   b.out_data,    32'h1111_0002);
        chk("t1_cnt1",      b.beat_cnt,    8'd1);
        chk("t1_rdy2_low",  b.in_ready[2], 1'b0);
        step();
        set_req(1, 1'b1, 32'h1111_0003, 1'b1);
        #1;
        chk("t1_b3_data",   b.out_data,    32'h1111_0003);
        chk("t1_b3_last",   b.out_last,    1'b1);
        chk("t1_cnt2",      b.beat_cnt,    8'd2);
        chk("t1_rdy2_low3", b.in_ready[2], 1'b0);
        step();
        set_req(1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t1_bubble_busy",    b.busy,      1'b0);
        chk("t1_bubble_owner",   b.owner,     16'h0000);
        chk("t1_bubble_cnt",     b.beat_cnt,  8'd0);
        chk("t1_bubble_arb_req", b.arb_req,   16'h0004);
        chk("t1_bubble_valid",   b.out_valid, 1'b0);
        step();
        #1;
        chk("t1_owner2",    b.owner,    16'h0004);
        chk("t1_req2_data", b.out_data, 32'h2222_0001);
        chk("t1_req2_last", b.out_last, 1'b1);
        chk("t1_req2_rdy",  b.in_ready, 16'h0004);
        step();
        set_req(2, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t1_end_busy",  b.busy,  1'b0);
        chk("t1_end_owner", b.owner, 16'h0000);

        // ---------------- req5 with out_ready toggling ----------------
        b.out_ready = 1'b0;
        set_req(5, 1'b1, 32'h5555_0000, 1'b0);
        #1;
        chk("t2_arb_req", b.arb_req, 16'h0020);
        step();
        b.out_ready = 1'b1;
        #1;
        chk("t2_owner",    b.owner,    16'h0020);
        chk("t2_b0_data",  b.out_data, 32'h5555_0000);
        chk("t2_in_ready", b.in_ready, 16'h0020);
        step();
        b.out_ready = 1'b0;
        set_req(5, 1'b1, 32'h5555_0001, 1'b0);
        #1;
        chk("t2_cnt_a",      b.beat_cnt,  8'd1);
        chk("t2_stall_rdy",  b.in_ready,  16'h0000);
        chk("t2_stall_vld",  b.out_valid, 1'b1);
        step();
        b.out_ready = 1'b1;
        #1;
        chk("t2_cnt_b",      b.beat_cnt, 8'd1);
        chk("t2_stall_data", b.out_data, 32'h5555_0001);
        step();
        b.out_ready = 1'b0;
        set_req(5, 1'b1, 32'h5555_0002, 1'b1);
        #1;
        chk("t2_cnt_c", b.beat_cnt, 8'd2);
        step();
        b.out_ready = 1'b1;
        #1;
        chk("t2_cnt_d",    b.beat_cnt, 8'd2);
        chk("t2_b2_data",  b.out_data, 32'h5555_0002);
        chk("t2_b2_last",  b.out_last, 1'b1);
        step();
        set_req(5, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t2_end_busy", b.busy,     1'b0);
        chk("t2_end_cnt",  b.beat_cnt, 8'd0);

        // ---------------- req0 drops valid mid-packet for 4 cycles ----------------
        set_req(0, 1'b1, 32'h0000_A001, 1'b0);
        #1;
        step();
        #1;
        chk("t3_owner",     b.owner,     16'h0001);
        chk("t3_out_valid", b.out_valid, 1'b1);
        step();
        // req3 also asks during the gap: it must not preempt
        set_req(0, 1'b0, 32'h0000_A002, 1'b0);
        set_req(3, 1'b1, 32'h3333_0001, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            #1;
            chk("t3_gap_valid", b.out_valid, 1'b0);
            chk("t3_gap_req",   b.arb_req,   16'h0000);
            chk("t3_gap_busy",  b.busy,      1'b1);
            chk("t3_gap_owner", b.owner,     16'h0001);
            chk("t3_gap_cnt",   b.beat_cnt,  8'd1);
        end
        step();
        set_req(0, 1'b1, 32'h0000_A002, 1'b1);
        #1;
        chk("t3_b2_valid", b.out_valid, 1'b1);
        chk("t3_b2_data",  b.out_data,  32'h0000_A002);
        chk("t3_b2_last",  b.out_last,  1'b1);
        step();
        set_req(0, 1'b0, 32'h0, 1'b0);
        set_req(3, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t3_end_busy",  b.busy,  1'b0);
        chk("t3_end_owner", b.owner, 16'h0000);

        // ---------------- reset during beat 2 of a 4-beat packet ----------------
        set_req(8, 1'b1, 32'h8888_0001, 1'b0);
        #1;
        step();
        #1;
        chk("t5_owner", b.owner, 16'h0100);
        step();
        set_req(8, 1'b1, 32'h8888_0002, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_cnt_pre", b.beat_cnt, 8'd1);
        step();
        rst_n = 1'b1;
        #1;
        chk("t5_owner_rst",    b.owner,     16'h0000);
        chk("t5_busy_rst",     b.busy,      1'b0);
        chk("t5_cnt_rst",      b.beat_cnt,  8'd0);
        chk("t5_in_ready_rst", b.in_ready,  16'h0000);
        chk("t5_arb_req_rst",  b.arb_req,   16'h0100);
        chk("t5_out_valid",    b.out_valid, 1'b0);
        set_req(8, 1'b0, 32'h0, 1'b0);

        // ---------------- illegal grant: two bits set ----------------
        step();
        set_req(0, 1'b1, 32'h0, 1'b1);
        set_req(1, 1'b1, 32'h0, 1'b1);
        force_en  = 1'b1;
        force_gnt = 16'h0003;
        #1;
        chk("t4a_err_pre", b.gnt_err, 1'b0);
        step();
        force_en = 1'b0;
        set_req(0, 1'b0, 32'h0, 1'b0);
        set_req(1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t4a_err",   b.gnt_err,   1'b1);
        chk("t4a_busy",  b.busy,      1'b0);
        chk("t4a_owner", b.owner,     16'h0000);
        // a legal packet afterwards still works and the flag stays set
        set_req(3, 1'b1, 32'h3333_0002, 1'b1);
        #1;
        step();
        #1;
        chk("t4a_pkt_owner", b.owner,    16'h0008);
        chk("t4a_pkt_data",  b.out_data, 32'h3333_0002);
        chk("t4a_err_hold",  b.gnt_err,  1'b1);
        step();
        set_req(3, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t4a_pkt_end",   b.busy,    1'b0);
        chk("t4a_err_hold2", b.gnt_err, 1'b1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("t4a_err_clr", b.gnt_err, 1'b0);

        // ---------------- illegal grant: bit not in in_valid ----------------
        set_req(0, 1'b1, 32'h0, 1'b1);
        force_en  = 1'b1;
        force_gnt = 16'h0010;
        #1;
        step();
        force_en = 1'b0;
        set_req(0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t4b_err",   b.gnt_err, 1'b1);
        chk("t4b_owner", b.owner,   16'h0000);
        chk("t4b_busy",  b.busy,    1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("t4b_err_clr", b.gnt_err, 1'b0);

        // ---------------- CNT_W=2 saturation, 6-beat packet ----------------
        set_req2(0, 1'b1, 32'hC000_0000, 1'b0);
        #1;
        step();
        #1;
        chk("t6_owner", b2.owner,    16'h0001);
        chk("t6_cnt0",  b2.beat_cnt, 2'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            set_req2(0, 1'b1, 32'hC000_0000 + DW'(k), (k == 5));
            #1;
            chk("t6_cnt_sat", b2.beat_cnt, sat_tab[k-1][1:0]);
            chk("t6_data",    b2.out_data, 32'hC000_0000 + DW'(k));
        end
        step();
        set_req2(0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t6_end_cnt",  b2.beat_cnt, 2'd0);
        chk("t6_end_busy", b2.busy,     1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
